// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - byte-stream loader for instruction memory; holds the core in reset until a verified image lands
module imem_boot_loader #(
    parameter int          ADDR_W  = 8,
    parameter int          TIMEOUT = 1000,
    parameter logic [7:0]  HDR     = 8'hA5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_WR,
        S_CHK,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic              active;
    logic [ADDR_W-1:0] n_words;
    logic [7:0]        xor_acc;
    logic [TW-1:0]     idle_cnt;

    logic              ready_st;
    logic              timing_st;
    logic              xfer;
    logic              timeout_hit;
    logic              len_over;
    logic              last_word;
    logic              chk_ok;

    // Decode which states accept bytes and which run the inter-byte idle timer.
    always_comb begin
        ready_st  = 1'b0;
        timing_st = 1'b0;
        case (state)
            S_IDLE:                   ready_st = 1'b1;
            S_LEN, S_HI, S_LO, S_CHK: begin
                ready_st  = 1'b1;
                timing_st = 1'b1;
            end
            default: ;
        endcase
    end

    // in_ready stays low until the first clock after reset release.
    assign in_ready    = active & ready_st;
    assign imem_we     = (state == S_WR);
    assign xfer        = in_valid & in_ready;
    assign timeout_hit = timing_st & ~xfer & (idle_cnt == TW'(TIMEOUT - 1));
    assign len_over    = (int'(in_data) > DEPTH);
    // The stored count is modulo depth, so LEN=0 and LEN=depth both end after a full wrap.
    assign last_word   = ((imem_addr + ADDR_W'(1)) == n_words);
    assign chk_ok      = (in_data == xor_acc);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; reload overrides any byte transfer in the same cycle.
    always_comb begin
        state_n = state;
        if (reload) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (xfer && in_data == HDR) state_n = S_LEN;
                S_LEN: begin
                    if (xfer)             state_n = len_over ? S_IDLE : S_HI;
                    else if (timeout_hit) state_n = S_IDLE;
                end
                S_HI: begin
                    if (xfer)             state_n = S_LO;
                    else if (timeout_hit) state_n = S_IDLE;
                end
                S_LO: begin
                    if (xfer)             state_n = S_WR;
                    else if (timeout_hit) state_n = S_IDLE;
                end
                S_WR:                     state_n = last_word ? S_CHK : S_HI;
                S_CHK: begin
                    if (xfer)             state_n = chk_ok ? S_DONE : S_IDLE;
                    else if (timeout_hit) state_n = S_IDLE;
                end
                S_DONE:                   state_n = S_DONE;
                default:                  state_n = S_IDLE;
            endcase
        end
    end

    // Datapath, counters and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active     <= 1'b0;
            n_words    <= '0;
            xor_acc    <= '0;
            idle_cnt   <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            active <= 1'b1;
            if (reload) begin
                n_words    <= '0;
                xor_acc    <= '0;
                idle_cnt   <= '0;
                imem_addr  <= '0;
                core_reset <= 1'b1;
                load_done  <= 1'b0;
                if (state == S_DONE) load_err <= 1'b0;
            end else begin
                if (timing_st && !xfer) idle_cnt <= idle_cnt + TW'(1);
                else                    idle_cnt <= '0;

                if (timeout_hit) load_err <= 1'b1;

                case (state)
                    S_LEN: if (xfer) begin
                        n_words   <= ADDR_W'(in_data);
                        imem_addr <= '0;
                        xor_acc   <= '0;
                        if (len_over) load_err <= 1'b1;
                    end
                    S_HI: if (xfer) begin
                        imem_wdata[15:8] <= in_data;
                        xor_acc          <= xor_acc ^ in_data;
                    end
                    S_LO: if (xfer) begin
                        imem_wdata[7:0] <= in_data;
                        xor_acc         <= xor_acc ^ in_data;
                    end
                    S_WR: imem_addr <= imem_addr + ADDR_W'(1);
                    S_CHK: if (xfer) begin
                        if (chk_ok) begin
                            core_reset <= 1'b0;
                            load_done  <= 1'b1;
                            load_err   <= 1'b0;
                        end else begin
                            load_done  <= 1'b0;
                            load_err   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Loads the 16-bit program image into instruction memory from a byte stream, then releases the single-cycle 16-bit core from reset.
- Sits upstream of the instruction memory write port and drives the core's active-high reset.
- The core fetches 16-bit words at byte address pc, so the loader's word index k is fetched at pc = 2*k.

Parameters:
- ADDR_W, 8, word-address width; image depth is 2**ADDR_W words.
- TIMEOUT, 1000, maximum idle clk cycles between bytes inside a frame before the frame aborts.
- HDR, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte; transfer occurs when in_valid & in_ready.
- reload  in  1  one-cycle request to re-enter loading.
- imem_we  out  1  instruction memory write strobe, one cycle.
- imem_addr  out  ADDR_W  word index.
- imem_wdata  out  16  word to write.
- core_reset  out  1  active-high reset to the core.
- load_done  out  1  last frame loaded and verified.
- load_err  out  1  last frame failed on checksum, timeout or overflow.

Behaviour:
- Reset (reset_n=0, asynchronous) drives: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, core_reset 1, load_done 0, load_err 0. The counters clear.
- in_ready is 1 in IDLE, LEN, HI, LO and CHK. It is 0 in WR and DONE.
- Frame format: HDR, then LEN (word count N, where 0 means 2**ADDR_W), then N word pairs sent high byte first, then CHK. CHK is the XOR of all 2N data bytes.
- IDLE: accepted byte == HDR goes to LEN. Any other byte is discarded and the state stays IDLE. load_done and load_err keep their previous values.
- LEN: store N, clear word_cnt, imem_addr and xor_acc, then go to HI. If N > 2**ADDR_W, which can only happen when ADDR_W < 8, set load_err and go to IDLE.
- HI: latch the byte into imem_wdata[15:8] and XOR it into xor_acc, then go to LO.
- LO: latch the byte into imem_wdata[7:0] and XOR it into xor_acc, then go to WR.
- WR: one cycle with imem_we=1, imem_addr=word_cnt, and stable data.
  - On the next edge word_cnt increments and imem_addr follows.
  - If the incremented count equals N (modulo 2**ADDR_W), go to CHK; otherwise go to HI.
  - Words land at addresses 0..N-1. The address wraps only in the N = 2**ADDR_W case, and only after the last write.
- CHK: a byte equal to xor_acc goes to DONE. Otherwise set load_err=1 and load_done=0, and go to IDLE with core_reset still 1.
- DONE: core_reset deasserts on the edge entering DONE. Set load_done=1 and load_err=0.
  - DONE is held until reload or reset_n; in_valid is ignored.
- reload: honoured in every state.
  - Next edge: core_reset=1, state IDLE, imem_we=0, counters cleared, load_done=0.
  - load_err is kept only if reload arrives outside DONE.
  - reload takes priority over a simultaneous byte transfer; that byte is dropped.
- Timeout: an idle counter runs in LEN, HI, LO and CHK. It clears on each accepted byte and on entry to these states.
  - When it reaches TIMEOUT-1 with no transfer, the next edge goes to IDLE, sets load_err=1 and keeps core_reset=1.
  - A transfer on that same cycle wins over the timeout.
- Memory content is not rolled back on failure. The core stays in reset until a fully verified frame arrives.
- reset_n asserted mid-frame aborts immediately to the reset values. Partially written words remain in memory.

Test Plan:
- Frame A5 02 12 34 AB CD 40, with in_valid held high → writes (0,0x1234) and (1,0xABCD), each with imem_we high for exactly 1 cycle. core_reset falls one cycle after the 0x40 transfer. load_done=1, load_err=0.
- Same frame with CHK=0x41 → both writes occur, then load_err=1, load_done=0, core_reset stays 1. A following correct frame A5 01 00 07 07 → (0,0x0007), then load_done=1 and core_reset=0.
- Garbage 00 FF 5A, then A5 01 80 01 81 → the garbage is ignored, (0,0x8001) is written, load_done=1.
- A5 03 11 22, then in_valid low for TIMEOUT cycles (1000) → on the 1000th idle cycle the state returns to IDLE with load_err=1 and core_reset=1. A following HDR is accepted.
- After DONE, pulse reload in the same cycle as a byte A5 → core_reset=1 next cycle, load_done=0, the A5 is dropped, and the state is IDLE with in_ready=1.
- LEN=00 with ADDR_W=8 → 256 writes to addresses 0..255, then correct CHK gives DONE. Assert reset_n low mid-data → all outputs return to reset values asynchronously.
